// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: latches the PC, reads instruction memory, holds the
// returned word for decode and pulses the PC increment once per completed fetch.
//
// state  | meaning
// -------+----------------------------------------------------------------
// IDLE   | no fetch in flight; samples fetch_req and pc_in
// REQ    | mem_rd asserted, waiting for mem_ready (bounded by MAX_WAIT)
// HOLD   | ir_out holds an unconsumed instruction, waiting for ir_ready
module instr_fetch_unit #(
   parameter int ADDR_W   = 6,
   parameter int DATA_W   = 16,
   parameter int MAX_WAIT = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [ADDR_W-1:0] pc_in,
   input  logic              fetch_req,
   input  logic              flush,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_rd,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              mem_ready,
   output logic [DATA_W-1:0] ir_out,
   output logic              ir_valid,
   input  logic              ir_ready,
   output logic              pc_inc,
   output logic              busy,
   output logic              fetch_err,
   output logic [7:0]        fetch_count
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_HOLD = 2'd2
   } state_t;

   // Last wait-counter value before a stalled read is declared a timeout.
   localparam logic [7:0] WAIT_LAST = 8'(MAX_WAIT - 1);

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
   logic              mem_rd_q, mem_rd_d;
   logic [DATA_W-1:0] ir_out_q, ir_out_d;
   logic              ir_valid_q, ir_valid_d;
   logic              pc_inc_q, pc_inc_d;
   logic              busy_q, busy_d;
   logic              fetch_err_q, fetch_err_d;
   logic [7:0]        fetch_count_q, fetch_count_d;
   logic [7:0]        wait_q, wait_d;

   // Next-state and next-output logic; every output is registered below.
   always_comb begin
      state_d       = state_q;
      mem_addr_d    = mem_addr_q;
      mem_rd_d      = mem_rd_q;
      ir_out_d      = ir_out_q;
      ir_valid_d    = ir_valid_q;
      pc_inc_d      = 1'b0;
      fetch_err_d   = fetch_err_q;
      fetch_count_d = fetch_count_q;
      wait_d        = wait_q;
      unique case (state_q)
         S_IDLE: begin
            if (fetch_req && !flush && !fetch_err_q) begin
               mem_addr_d = pc_in;
               mem_rd_d   = 1'b1;
               wait_d     = 8'd0;
               state_d    = S_REQ;
            end
         end
         S_REQ: begin
            if (flush) begin
               mem_rd_d = 1'b0;
               state_d  = S_IDLE;
            end else if (mem_ready) begin
               ir_out_d      = mem_rdata;
               ir_valid_d    = 1'b1;
               pc_inc_d      = 1'b1;
               fetch_count_d = fetch_count_q + 8'd1;
               mem_rd_d      = 1'b0;
               state_d       = S_HOLD;
            end else if (wait_q == WAIT_LAST) begin
               fetch_err_d = 1'b1;
               mem_rd_d    = 1'b0;
               state_d     = S_IDLE;
            end else begin
               wait_d = wait_q + 8'd1;
            end
         end
         S_HOLD: begin
            // A flush here loses the instruction; the PC has already advanced.
            if (flush || ir_ready) begin
               ir_valid_d = 1'b0;
               state_d    = S_IDLE;
            end
         end
         default: begin
            state_d  = S_IDLE;
            mem_rd_d = 1'b0;
         end
      endcase
      busy_d = (state_d != S_IDLE);
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= S_IDLE;
         mem_addr_q    <= '0;
         mem_rd_q      <= 1'b0;
         ir_out_q      <= '0;
         ir_valid_q    <= 1'b0;
         pc_inc_q      <= 1'b0;
         busy_q        <= 1'b0;
         fetch_err_q   <= 1'b0;
         fetch_count_q <= 8'd0;
         wait_q        <= 8'd0;
      end else begin
         state_q       <= state_d;
         mem_addr_q    <= mem_addr_d;
         mem_rd_q      <= mem_rd_d;
         ir_out_q      <= ir_out_d;
         ir_valid_q    <= ir_valid_d;
         pc_inc_q      <= pc_inc_d;
         busy_q        <= busy_d;
         fetch_err_q   <= fetch_err_d;
         fetch_count_q <= fetch_count_d;
         wait_q        <= wait_d;
      end
   end

   assign mem_addr    = mem_addr_q;
   assign mem_rd      = mem_rd_q;
   assign ir_out      = ir_out_q;
   assign ir_valid    = ir_valid_q;
   assign pc_inc      = pc_inc_q;
   assign busy        = busy_q;
   assign fetch_err   = fetch_err_q;
   assign fetch_count = fetch_count_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: a transaction-level memory/decode/PC model drives
// randomized latencies and backpressure and checks each completed fetch.
module tb_instr_fetch_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic [5:0]  pc_in;
   logic        fetch_req;
   logic        flush;
   logic [5:0]  mem_addr;
   logic        mem_rd;
   logic [15:0] mem_rdata;
   logic        mem_ready;
   logic [15:0] ir_out;
   logic        ir_valid;
   logic        ir_ready;
   logic        pc_inc;
   logic        busy;
   logic        fetch_err;
   logic [7:0]  fetch_count;

   int          checks = 0;
   int          failures = 0;
   int          cyc = 0;
   logic        inc_prev = 1'b0;
   logic [7:0]  fc_exp = 8'd0;
   logic [15:0] mem [64];

   instr_fetch_unit #(.ADDR_W(6), .DATA_W(16), .MAX_WAIT(8)) dut (
      .clk(clk), .rst(rst), .pc_in(pc_in), .fetch_req(fetch_req), .flush(flush),
      .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
      .ir_out(ir_out), .ir_valid(ir_valid), .ir_ready(ir_ready), .pc_inc(pc_inc),
      .busy(busy), .fetch_err(fetch_err), .fetch_count(fetch_count)
   );

   always #5 clk = ~clk;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // One clock; the program counter peer applies a pc_inc seen last cycle.
   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
      if (inc_prev) pc_in = pc_in + 6'd1;
      inc_prev = pc_inc;
   endtask

   task automatic check_reset_values(input string tag);
      checks++;
      if (mem_addr !== 6'd0 || mem_rd !== 1'b0 || ir_out !== 16'd0 || ir_valid !== 1'b0 ||
          pc_inc !== 1'b0 || busy !== 1'b0 || fetch_err !== 1'b0 || fetch_count !== 8'd0) begin
         failures++;
         $display("FAIL %s: addr=%0d rd=%b ir=%h v=%b inc=%b busy=%b err=%b cnt=%0d, required all zero",
                  tag, mem_addr, mem_rd, ir_out, ir_valid, pc_inc, busy, fetch_err, fetch_count);
      end
   endtask

   // One complete fetch: memory answers after lat wait cycles, decode accepts
   // after bp stall cycles. DUT must be IDLE on entry.
   task automatic do_fetch(input int lat, input int bp, input logic [5:0] exp_addr);
      int n, rd_cycles, v_cycles, incs, unstable;
      logic [15:0] w;
      w = mem[exp_addr];
      fetch_req = 1'b1; flush = 1'b0; mem_ready = 1'b0; ir_ready = 1'b0;
      n = 0;
      do begin tick(); n++; end while (mem_rd !== 1'b1 && n < 20);
      checks++;
      if (n != 1 || mem_rd !== 1'b1) begin
         failures++;
         $display("FAIL fetch_start: mem_rd=%b after %0d cycles, required 1 after 1", mem_rd, n);
      end
      checks++;
      if (mem_addr !== exp_addr || busy !== 1'b1) begin
         failures++;
         $display("FAIL fetch_addr: mem_addr=%0d busy=%b, required %0d busy=1", mem_addr, busy, exp_addr);
      end
      rd_cycles = 0; incs = 0; unstable = 0;
      while (mem_rd === 1'b1 && rd_cycles < 40) begin
         if (mem_addr !== exp_addr) unstable++;
         mem_ready = (rd_cycles == lat);
         mem_rdata = mem_ready ? w : 16'($urandom);
         rd_cycles++;
         tick();
         if (pc_inc === 1'b1) incs++;
      end
      mem_ready = 1'b0; mem_rdata = 16'($urandom);
      checks++;
      if (rd_cycles != lat + 1 || unstable != 0) begin
         failures++;
         $display("FAIL rd_cycles: mem_rd high %0d cycles (addr moves %0d), required %0d", rd_cycles, unstable, lat + 1);
      end
      fc_exp = fc_exp + 8'd1;
      checks++;
      if (ir_valid !== 1'b1 || ir_out !== w || fetch_count !== fc_exp) begin
         failures++;
         $display("FAIL ir_capture: v=%b ir=%h cnt=%0d, required v=1 ir=%h cnt=%0d", ir_valid, ir_out, fetch_count, w, fc_exp);
      end
      v_cycles = 0;
      while (ir_valid === 1'b1 && v_cycles < 40) begin
         if (ir_out !== w) unstable++;
         ir_ready = (v_cycles == bp);
         v_cycles++;
         tick();
         if (pc_inc === 1'b1) incs++;
      end
      ir_ready = 1'b0;
      checks++;
      if (v_cycles != bp + 1 || incs != 1 || unstable != 0 || busy !== 1'b0) begin
         failures++;
         $display("FAIL hold_phase: valid %0d cycles, pc_inc %0d, ir changes %0d, busy=%b; required %0d, 1, 0, 0",
                  v_cycles, incs, unstable, busy, bp + 1);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; fetch_req = 1'b0; flush = 1'b0; mem_ready = 1'b0; ir_ready = 1'b0;
      mem_rdata = 16'h0; pc_in = 6'd5;
      tick(); tick();
      check_reset_values("reset");
      rst = 1'b0;
      tick();
      check_reset_values("idle_after_reset");
   endtask

   task automatic test_basic_fetch();
      do_fetch(0, 0, 6'd5);
      fetch_req = 1'b0;
      checks++;
      if (ir_out !== 16'hA5C3 || pc_in !== 6'd6 || fetch_count !== 8'd1) begin
         failures++;
         $display("FAIL basic: ir=%h pc=%0d cnt=%0d, required a5c3 6 1", ir_out, pc_in, fetch_count);
      end
      tick();
   endtask

   task automatic test_wait_backpressure();
      do_fetch(3, 3, 6'd6);
      fetch_req = 1'b0;
      tick();
   endtask

   task automatic test_flush_req();
      fetch_req = 1'b1;
      tick();
      checks++;
      if (mem_rd !== 1'b1 || mem_addr !== 6'd7) begin
         failures++;
         $display("FAIL flush_req_start: rd=%b addr=%0d, required 1 7", mem_rd, mem_addr);
      end
      mem_ready = 1'b1; mem_rdata = 16'hDEAD; flush = 1'b1; fetch_req = 1'b0;
      tick();
      checks++;
      if (ir_valid !== 1'b0 || pc_inc !== 1'b0 || busy !== 1'b0 || mem_rd !== 1'b0 || fetch_count !== fc_exp) begin
         failures++;
         $display("FAIL flush_req: v=%b inc=%b busy=%b rd=%b cnt=%0d, required 0 0 0 0 %0d",
                  ir_valid, pc_inc, busy, mem_rd, fetch_count, fc_exp);
      end
      flush = 1'b0; mem_ready = 1'b0;
      tick();
      checks++;
      if (ir_valid !== 1'b0 || pc_in !== 6'd7) begin
         failures++;
         $display("FAIL flush_req_after: v=%b pc=%0d, required 0 7", ir_valid, pc_in);
      end
   endtask

   task automatic test_flush_hold();
      fetch_req = 1'b1;
      tick();
      mem_ready = 1'b1; mem_rdata = mem[7]; fetch_req = 1'b0;
      tick();
      fc_exp = fc_exp + 8'd1;
      checks++;
      if (ir_valid !== 1'b1 || pc_inc !== 1'b1 || fetch_count !== fc_exp) begin
         failures++;
         $display("FAIL flush_hold_capture: v=%b inc=%b cnt=%0d, required 1 1 %0d", ir_valid, pc_inc, fetch_count, fc_exp);
      end
      mem_ready = 1'b0; flush = 1'b1;
      tick();
      checks++;
      if (ir_valid !== 1'b0 || busy !== 1'b0 || fetch_count !== fc_exp || pc_in !== 6'd8) begin
         failures++;
         $display("FAIL flush_hold: v=%b busy=%b cnt=%0d pc=%0d, required 0 0 %0d 8", ir_valid, busy, fetch_count, pc_in, fc_exp);
      end
      flush = 1'b0;
   endtask

   task automatic test_back_to_back();
      int start;
      start = cyc;
      for (int i = 0; i < 4; i++) do_fetch(0, 0, 6'(8 + i));
      checks++;
      if (cyc - start != 12) begin
         failures++;
         $display("FAIL back_to_back: 4 fetches took %0d cycles, required 12", cyc - start);
      end
      fetch_req = 1'b0;
      tick();
   endtask

   task automatic test_reset_mid();
      fetch_req = 1'b1;
      tick();
      checks++;
      if (mem_rd !== 1'b1 || mem_addr !== 6'd12) begin
         failures++;
         $display("FAIL reset_mid_start: rd=%b addr=%0d, required 1 12", mem_rd, mem_addr);
      end
      mem_ready = 1'b1; mem_rdata = 16'hBEEF; rst = 1'b1;
      tick();
      check_reset_values("reset_mid");
      rst = 1'b0; mem_ready = 1'b0; fetch_req = 1'b0; fc_exp = 8'd0; inc_prev = 1'b0;
      tick();
      check_reset_values("reset_mid_after");
   endtask

   task automatic test_timeout();
      int n, stray;
      fetch_req = 1'b1;
      tick();
      n = 0;
      while (mem_rd === 1'b1 && n < 30) begin
         n++;
         tick();
      end
      checks++;
      if (n != 8 || fetch_err !== 1'b1 || busy !== 1'b0) begin
         failures++;
         $display("FAIL timeout: mem_rd high %0d cycles err=%b busy=%b, required 8 1 0", n, fetch_err, busy);
      end
      stray = 0;
      for (int i = 0; i < 10; i++) begin
         tick();
         if (mem_rd !== 1'b0 || busy !== 1'b0 || fetch_err !== 1'b1) stray++;
      end
      checks++;
      if (stray != 0) begin
         failures++;
         $display("FAIL timeout_sticky: %0d cycles with activity or cleared err, required 0", stray);
      end
      fetch_req = 1'b0; rst = 1'b1;
      tick();
      rst = 1'b0; fc_exp = 8'd0; inc_prev = 1'b0;
      tick();
      check_reset_values("timeout_cleared");
   endtask

   task automatic test_sequential_wrap();
      int gap, idle_bad;
      logic [7:0] prev_fc;
      logic wrap_seen;
      pc_in = 6'd62;
      for (int i = 0; i < 4; i++) do_fetch($urandom_range(0, 2), $urandom_range(0, 2), 6'(62 + i));
      idle_bad = 0; wrap_seen = 1'b0;
      for (int i = 0; i < 256; i++) begin
         prev_fc = fetch_count;
         if ($urandom_range(0, 3) == 0) begin
            fetch_req = 1'b0;
            gap = $urandom_range(1, 3);
            for (int g = 0; g < gap; g++) begin
               tick();
               if (mem_rd !== 1'b0 || busy !== 1'b0) idle_bad++;
            end
         end
         do_fetch($urandom_range(0, 6), $urandom_range(0, 3), 6'(2 + i));
         if (prev_fc == 8'd255 && fetch_count == 8'd0) wrap_seen = 1'b1;
      end
      checks++;
      if (idle_bad != 0 || wrap_seen !== 1'b1) begin
         failures++;
         $display("FAIL seq_wrap: idle violations %0d wrap_seen=%b, required 0 1", idle_bad, wrap_seen);
      end
      fetch_req = 1'b0;
      tick();
   endtask

   initial begin
      for (int i = 0; i < 64; i++) mem[i] = 16'($urandom);
      mem[5] = 16'hA5C3;
      test_reset();
      test_basic_fetch();
      test_wait_backpressure();
      test_flush_req();
      test_flush_hold();
      test_back_to_back();
      test_reset_mid();
      test_timeout();
      test_sequential_wrap();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
